apb2axi_resp_tracker: RTL
=========================

# apb2axi_resp_tracker

Parametrised completion tracker for the APB2AXI bridge. It sits between the AXI B/R response channels and the completion queue (CQ) FIFO, and supersedes the fixed single-path response collector. It keeps a per-ID table of outstanding transactions registered by the write/read builders. It counts R beats against the issued burst length and merges the worst-case response across a burst. It pushes one tagged completion word per transaction into the CQ, with protocol-error and unexpected-ID detection.

## Interface
- AXI_ID_W, default 4: ID width; the table has 2**AXI_ID_W entries, one outstanding transaction per ID.
- TAG_W, default 4: directory tag width carried to the completion.
- TIMEOUT_CYC, default 1024: watchdog limit in cycles; used only with APB2AXI_TRK_TIMEOUT_EN.
- CPL_W, derived, TAG_W+4: completion word width.

- aclk  in  1  clock; one clock for the whole block.
- aresetn  in  1  asynchronous active-low reset.
- iss_valid  in  1  builder registers a transaction at AW/AR handshake.
- iss_ready  out  1  entry for iss_id is free.
- iss_id  in  AXI_ID_W  AXI ID of the issued transaction.
- iss_tag  in  TAG_W  directory tag.
- iss_is_write  in  1  1 = write (B expected), 0 = read (R expected).
- iss_len  in  4  AXI3 AxLEN; beats = iss_len+1.
- bid / bresp / bvalid  in  AXI_ID_W / 2 / 1  AXI B channel.
- bready  out  1  B channel ready.
- rid / rresp / rlast / rvalid  in  AXI_ID_W / 2 / 1 / 1  AXI R channel; data is not used here.
- rready  out  1  R channel ready.
- cq_push_valid  out  1  completion word valid.
- cq_push_ready  in  1  CQ can accept.
- cq_push_data  out  CPL_W  [CPL_W-1:4] = tag, [3] = is_write, [2] = proto_err, [1:0] = merged resp.
- outst_cnt  out  AXI_ID_W+1  number of valid table entries.
- unexp_pulse  out  1  one-cycle pulse when a B or R handshake hits an invalid entry or a wrong-direction entry.

## Operation
- Each table entry holds: valid, is_write, tag, len, beat_cnt[4:0], resp[1:0], perr.
- Issue: a handshake occurs when iss_valid && iss_ready, where iss_ready = !entry[iss_id].valid.
  - The entry is loaded with beat_cnt = 0, resp = 0, perr = 0.
- Output slot: one register holding cq_push_valid and cq_push_data.
  - slot_free = !cq_push_valid || cq_push_ready.
- bready = slot_free.
- rready = 1 for a beat with rlast = 0; rready = slot_free && !bvalid for a beat with rlast = 1. B has priority over a last R beat.
- B handshake on a valid write entry:
  - loads the slot with {tag, 1, perr, bresp};
  - frees the entry.
- R beat on a valid read entry:
  - resp becomes max(resp, rresp); numeric max gives DECERR > SLVERR > EXOKAY > OKAY;
  - beat_cnt increments and saturates at 16;
  - a non-last beat with beat_cnt already at len+1 sets perr.
- R last beat:
  - perr is set if beat_cnt != len;
  - the slot is loaded with {tag, 0, perr', max(resp, rresp)};
  - the entry is freed.
- B or R on an invalid entry or a wrong-direction entry:
  - the beat is accepted under the same ready rules and discarded;
  - unexp_pulse fires;
  - the table is unchanged and no completion is produced.
- outst_cnt: +1 on issue, −1 on completion load; both in the same cycle leave it unchanged.

## Timing
- Reset values:
  - cq_push_valid = 0, cq_push_data = 0, outst_cnt = 0, unexp_pulse = 0;
  - all entries invalid;
  - iss_ready, bready and rready read 1, since they are combinational from the empty state.
- Latency: a B handshake or R-last handshake in cycle N gives cq_push_valid = 1 in cycle N+1.
- The slot holds its data stable until cq_push_ready. With cq_push_ready high, a new completion can load every cycle.
- Issue and completion for the same ID in the same cycle: the issue stalls, because iss_ready reflects the pre-free state. It is accepted in N+1.
- Issue and completion for different IDs in the same cycle: both take effect.
- Reset mid-burst: all state is cleared immediately. A partially collected completion is lost.

## Configuration
- APB2AXI_TRK_TIMEOUT_EN defined:
  - each valid entry has an age counter, cleared on issue and on every R beat for that entry;
  - when the counter reaches TIMEOUT_CYC, the entry forces a completion {tag, is_write, 1, 2'b10};
  - the forced completion is loaded only when slot_free and no B or R-last is being loaded in that cycle; among expired entries the lowest ID wins;
  - the entry is then freed, and late responses for it raise unexp_pulse.
- APB2AXI_TRK_TIMEOUT_EN undefined: no counters exist; TIMEOUT_CYC is ignored; entries wait indefinitely.

## Test plan
- Write: issue ID 2, tag 5, len 0; BRESP = OKAY → cq_push_data = {5, 1, 0, 00} one cycle later; outst_cnt goes 1 → 0.
- Read burst: ID 1, tag 3, len 3; rresp sequence 0, 2, 0, 0 with rlast on beat 4 → single completion {3, 0, 0, 10}.
- Short burst: len 3, rlast on beat 2 → proto_err = 1. Long burst: 5 beats, rlast on beat 5 → proto_err = 1.
- Contention: bvalid and R-last valid in the same cycle with cq_push_ready = 0 for 3 cycles → bready = 0 and rready = 0 until the slot drains; the B completion is pushed first, then the R completion.
- Unexpected: bvalid with bid = 7, entry invalid → bready = 1, unexp_pulse = 1 for one cycle, no CQ push. A second issue to busy ID 1 → iss_ready = 0.
- With APB2AXI_TRK_TIMEOUT_EN and TIMEOUT_CYC = 16: read issued, no R → completion {tag, 0, 1, 10} after 16 cycles; a late R beat raises unexp_pulse.

Source files
------------

// File: rtl/apb2axi_resp_tracker.sv
// Per-ID completion tracker for the APB2AXI bridge: collects AXI B/R responses and pushes one tagged word per transaction.
// Optional watchdog: define APB2AXI_TRK_TIMEOUT_EN to force-complete entries idle for TIMEOUT_CYC cycles.
module apb2axi_resp_tracker #(
  parameter int unsigned AXI_ID_W    = 4,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned CPL_W      = TAG_W + 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [AXI_ID_W-1:0] iss_id,
  input  logic [TAG_W-1:0]    iss_tag,
  input  logic                iss_is_write,
  input  logic [3:0]          iss_len,
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic                cq_push_valid,
  input  logic                cq_push_ready,
  output logic [CPL_W-1:0]    cq_push_data,
  output logic [AXI_ID_W:0]   outst_cnt,
  output logic                unexp_pulse
);

  localparam int unsigned N = 1 << AXI_ID_W;

  logic [N-1:0]     vld_q;
  logic [N-1:0]     wr_q;
  logic [N-1:0]     perr_q;
  logic [TAG_W-1:0] tag_q  [N];
  logic [3:0]       len_q  [N];
  logic [4:0]       bcnt_q [N];
  logic [1:0]       resp_q [N];

  logic                slot_free;
  logic                iss_hs;
  logic                b_hs, b_ok;
  logic                r_hs, r_ok, r_last_ok;
  logic [1:0]          r_max;
  logic                r_perr_last, r_perr_mid;
  logic                to_fire;
  logic [AXI_ID_W-1:0] to_id;
  logic                ld;
  logic [CPL_W-1:0]    ld_data;

  // Handshakes and response classification; B wins over a last R beat
  always_comb begin
    slot_free   = !cq_push_valid || cq_push_ready;
    iss_ready   = !vld_q[iss_id];
    bready      = slot_free;
    rready      = rlast ? (slot_free && !bvalid) : 1'b1;
    iss_hs      = iss_valid && iss_ready;
    b_hs        = bvalid && bready;
    r_hs        = rvalid && rready;
    b_ok        = b_hs && vld_q[bid] && wr_q[bid];
    r_ok        = r_hs && vld_q[rid] && !wr_q[rid];
    r_last_ok   = r_ok && rlast;
    r_max       = (rresp > resp_q[rid]) ? rresp : resp_q[rid];
    r_perr_last = perr_q[rid] || (bcnt_q[rid] != 5'(len_q[rid]));
    r_perr_mid  = perr_q[rid] || (bcnt_q[rid] == (5'(len_q[rid]) + 5'd1));
  end

`ifdef APB2AXI_TRK_TIMEOUT_EN
  localparam int unsigned AGE_W = $clog2(TIMEOUT_CYC + 1);

  logic [AGE_W-1:0] age_q [N];
  logic             to_any;

  // Lowest expired ID is chosen; it may only load when no real response does
  always_comb begin
    to_any = 1'b0;
    to_id  = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vld_q[i] && (age_q[i] == AGE_W'(TIMEOUT_CYC))) begin
        to_any = 1'b1;
        to_id  = AXI_ID_W'(i);
      end
    end
    to_fire = to_any && slot_free && !b_ok && !r_last_ok;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(N); i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (iss_hs && (iss_id == AXI_ID_W'(i)))
          age_q[i] <= '0;
        else if (r_ok && (rid == AXI_ID_W'(i)))
          age_q[i] <= '0;
        else if (vld_q[i] && (age_q[i] != AGE_W'(TIMEOUT_CYC)))
          age_q[i] <= age_q[i] + AGE_W'(1);
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT_CYC);
  assign to_fire = 1'b0;
  assign to_id   = '0;
`endif

  // Completion word selection
  always_comb begin
    ld      = b_ok || r_last_ok || to_fire;
    ld_data = '0;
    if (b_ok)
      ld_data = {tag_q[bid], 1'b1, perr_q[bid], bresp};
    else if (r_last_ok)
      ld_data = {tag_q[rid], 1'b0, r_perr_last, r_max};
    else if (to_fire)
      ld_data = {tag_q[to_id], wr_q[to_id], 1'b1, 2'b10};
  end

  // Transaction table; a freed entry is never the one being issued
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q  <= '0;
      wr_q   <= '0;
      perr_q <= '0;
      for (int i = 0; i < int'(N); i++) begin
        tag_q[i]  <= '0;
        len_q[i]  <= '0;
        bcnt_q[i] <= '0;
        resp_q[i] <= '0;
      end
    end else begin
      if (iss_hs) begin
        vld_q[iss_id]  <= 1'b1;
        wr_q[iss_id]   <= iss_is_write;
        tag_q[iss_id]  <= iss_tag;
        len_q[iss_id]  <= iss_len;
        bcnt_q[iss_id] <= '0;
        resp_q[iss_id] <= '0;
        perr_q[iss_id] <= 1'b0;
      end
      if (r_ok) begin
        resp_q[rid] <= r_max;
        bcnt_q[rid] <= (bcnt_q[rid] == 5'd16) ? 5'd16 : bcnt_q[rid] + 5'd1;
        if (rlast) begin
          perr_q[rid] <= r_perr_last;
          vld_q[rid]  <= 1'b0;
        end else begin
          perr_q[rid] <= r_perr_mid;
        end
      end
      if (b_ok)
        vld_q[bid] <= 1'b0;
      if (to_fire)
        vld_q[to_id] <= 1'b0;
    end
  end

  // Output slot, outstanding count and unexpected-response pulse
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cq_push_valid <= 1'b0;
      cq_push_data  <= '0;
      outst_cnt     <= '0;
      unexp_pulse   <= 1'b0;
    end else begin
      if (ld) begin
        cq_push_valid <= 1'b1;
        cq_push_data  <= ld_data;
      end else if (cq_push_ready) begin
        cq_push_valid <= 1'b0;
      end
      if (iss_hs && !ld)
        outst_cnt <= outst_cnt + (AXI_ID_W+1)'(1);
      else if (!iss_hs && ld)
        outst_cnt <= outst_cnt - (AXI_ID_W+1)'(1);
      unexp_pulse <= (b_hs && !b_ok) || (r_hs && !r_ok);
    end
  end

endmodule
